// File: rtl/async_fifo_if.sv
// rtl/async_fifo_if.sv - producer/consumer bus for async_fifo; ASYNC_FIFO_ERR_FLAGS_EN adds OVERFLOW/UNDERFLOW
interface async_fifo_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] DataOut;
    logic              WR;
    logic              RD;
    logic              EN;
    logic              FULL;
    logic              EMPTY;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic              OVERFLOW;
    logic              UNDERFLOW;

    modport master (
        output DataIn, WR, RD, EN,
        input  DataOut, FULL, EMPTY, OVERFLOW, UNDERFLOW
    );
    modport slave (
        input  DataIn, WR, RD, EN,
        output DataOut, FULL, EMPTY, OVERFLOW, UNDERFLOW
    );
`else
    modport master (
        output DataIn, WR, RD, EN,
        input  DataOut, FULL, EMPTY
    );
    modport slave (
        input  DataIn, WR, RD, EN,
        output DataOut, FULL, EMPTY
    );
`endif
endinterface

// File: rtl/async_fifo.sv
// rtl/async_fifo.sv - single-clock FIFO with registered FULL/EMPTY; ASYNC_FIFO_ERR_FLAGS_EN adds sticky error flags
module async_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    async_fifo_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       count;
    logic [AW:0]       count_nxt;
    logic              full_q;
    logic              empty_q;
    logic [DATA_W-1:0] dout_q;
    logic              wr_ok;
    logic              rd_ok;

    // Acceptance uses the registered flags, i.e. the pre-edge occupancy.
    assign wr_ok = bus.EN & bus.WR & ~full_q;
    assign rd_ok = bus.EN & bus.RD & ~empty_q;

    always_comb begin
        count_nxt = count;
        if (wr_ok && !rd_ok) begin
            count_nxt = count + CNT_ONE;
        end else if (rd_ok && !wr_ok) begin
            count_nxt = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            dout_q  <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_ok) begin
                dout_q <= mem[rptr];
                rptr   <= rptr + PTR_ONE;
            end
            count   <= count_nxt;
            full_q  <= (count_nxt == FULL_CNT);
            empty_q <= (count_nxt == '0);
        end
    end

    // Storage is not reset; a write coinciding with rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wptr] <= bus.DataIn;
        end
    end

    assign bus.DataOut = dout_q;
    assign bus.FULL    = full_q;
    assign bus.EMPTY   = empty_q;

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.EN && bus.WR && full_q) begin
                ovf_q <= 1'b1;
            end
            if (bus.EN && bus.RD && empty_q) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign bus.OVERFLOW  = ovf_q;
    assign bus.UNDERFLOW = unf_q;
`endif
endmodule

// File: tb/tb_async_fifo.sv
// tb/tb_async_fifo.sv - scoreboard bench for async_fifo: directed plan then random traffic
module tb_async_fifo;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    async_fifo_if #(.DATA_W(DATA_W)) bus ();

    async_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    string       phase    = "init";

    logic [DATA_W-1:0] model_q [$];
    logic [DATA_W-1:0] exp_q   [$];
    logic [DATA_W-1:0] model_dout = '0;
    logic              model_ovf  = 1'b0;
    logic              model_unf  = 1'b0;

    task automatic check(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s/%s got=%h exp=%h", phase, name, got, exp);
        end
    endtask

    // Drive one cycle, advance the reference model, then compare flags and output.
    task automatic step(input logic r, input logic en, input logic wr, input logic rd,
                        input logic [DATA_W-1:0] din);
        bit was_full;
        bit was_empty;
        @(negedge clk);
        rst        = r;
        bus.EN     = en;
        bus.WR     = wr;
        bus.RD     = rd;
        bus.DataIn = din;
        if (r) begin
            model_q.delete();
            model_dout = '0;
            model_ovf  = 1'b0;
            model_unf  = 1'b0;
        end else if (en) begin
            was_full  = (model_q.size() == DEPTH);
            was_empty = (model_q.size() == 0);
            if (wr && was_full)  model_ovf = 1'b1;
            if (rd && was_empty) model_unf = 1'b1;
            if (rd && !was_empty) begin
                model_dout = model_q.pop_front();
                exp_q.push_back(model_dout);
            end
            if (wr && !was_full) model_q.push_back(din);
        end
        @(posedge clk);
        #1;
        check("EMPTY",   {31'd0, bus.EMPTY}, {31'd0, model_q.size() == 0});
        check("FULL",    {31'd0, bus.FULL},  {31'd0, model_q.size() == DEPTH});
        check("DataOut", bus.DataOut, model_dout);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        check("OVERFLOW",  {31'd0, bus.OVERFLOW},  {31'd0, model_ovf});
        check("UNDERFLOW", {31'd0, bus.UNDERFLOW}, {31'd0, model_unf});
`endif
    endtask

    // Monitor: every read the DUT accepts must match the next scoreboard entry.
    initial begin
        logic take;
        forever begin
            @(posedge clk);
            take = !rst && bus.EN && bus.RD && !bus.EMPTY;
            #1;
            if (take) begin
                if (exp_q.size() == 0) begin
                    check("rd_unexpected", 32'd1, 32'd0);
                end else begin
                    check("rd_data", bus.DataOut, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bus.EN = 1'b0; bus.WR = 1'b0; bus.RD = 1'b0; bus.DataIn = '0;

        phase = "reset";
        step(1, 0, 0, 0, '0);
        step(1, 0, 0, 0, '0);
        step(0, 0, 0, 0, '0);

        phase = "fill";
        for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 0, 32'h1111_0001 + i);

        phase = "overfill";
        step(0, 1, 1, 0, 32'hDEAD_BEEF);

        phase = "drain";
        for (int i = 0; i < DEPTH + 1; i++) step(0, 1, 0, 1, '0);
        check("last_hold", bus.DataOut, 32'h1111_0008);

        phase = "wrap";
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 32'h2222_0000 + i);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, '0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 1, 32'h3333_0000 + i);
        check("count2", model_q.size(), 32'd2);

        phase = "en_gate";
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 32'h4444_4444);

        phase = "mid_reset";
        step(0, 1, 1, 0, 32'h5555_0001);
        step(1, 1, 1, 1, 32'h5555_0002);
        step(0, 1, 0, 1, '0);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom());
        end

        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
